// File: rtl/robot_pkg.sv
// Shared encodings and default timing for the wall-following robot move scheduler.
// Also used by the top that hosts the navigation FSM.
package robot_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SAMPLE = 3'd1,
        S_DECIDE = 3'd2,
        S_EXEC   = 3'd3,
        S_SETTLE = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_FWD  = 2'd1,
        CMD_ROT  = 2'd2
    } cmd_t;

    localparam int unsigned MOVE_CYCLES_DEF   = 16;
    localparam int unsigned ROT_CYCLES_DEF    = 8;
    localparam int unsigned SETTLE_CYCLES_DEF = 4;
    localparam int unsigned SENS_TIMEOUT_DEF  = 32;
    localparam int unsigned MAX_ROT_DEF       = 4;
    localparam int unsigned TMR_W_DEF         = 8;

    // A command asking for both front and rotate resolves to a rotate.
    function automatic cmd_t decode_cmd(input logic front, input logic rotate);
        if (rotate) begin
            return CMD_ROT;
        end
        if (front) begin
            return CMD_FWD;
        end
        return CMD_NONE;
    endfunction

endpackage

// File: rtl/robot_step_timer.sv
// Loadable down-counter that times every scheduler phase.
// Holds at zero until reloaded.
module robot_step_timer #(
    parameter int unsigned TMR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic [TMR_W-1:0] value,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - TMR_W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/robot_move_scheduler.sv
// Steps the robot one move at a time: sensor handshake, nav/manual arbitration,
// timed motor pulse, settle; halts on sensor timeout or repeated rotates.
module robot_move_scheduler
    import robot_pkg::*;
#(
    parameter int unsigned MOVE_CYCLES   = MOVE_CYCLES_DEF,
    parameter int unsigned ROT_CYCLES    = ROT_CYCLES_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned SENS_TIMEOUT  = SENS_TIMEOUT_DEF,
    parameter int unsigned MAX_ROT       = MAX_ROT_DEF,
    parameter int unsigned TMR_W         = TMR_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic sens_req,
    input  logic sens_ack,
    input  logic sens_head,
    input  logic sens_left,
    output logic head,
    output logic left,
    output logic nav_step,
    input  logic nav_front,
    input  logic nav_rotate,
    input  logic man_req,
    input  logic man_front,
    input  logic man_rotate,
    output logic man_gnt,
    output logic motor_fwd,
    output logic motor_rot,
    output logic busy,
    output logic stuck,
    output logic fault
);

    localparam int unsigned RC_W = $clog2(MAX_ROT + 1);

    state_t            state;
    state_t            nxt;
    cmd_t              cmd;
    cmd_t              cmd_nxt;
    logic [RC_W-1:0]   rot_cnt;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic [TMR_W-1:0]  tmr_value;
    logic              tmr_zero;

    always_comb begin
        nxt     = state;
        cmd_nxt = cmd;
        case (state)
            S_IDLE: begin
                if (enable) nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                // An ack arriving in the expiry cycle beats the timeout.
                if (!enable)        nxt = S_IDLE;
                else if (sens_ack)  nxt = S_DECIDE;
                else if (tmr_zero)  nxt = S_HALT;
            end
            S_DECIDE: begin
                cmd_nxt = man_req ? decode_cmd(man_front, man_rotate)
                                  : decode_cmd(nav_front, nav_rotate);
                nxt     = (cmd_nxt == CMD_NONE) ? S_SETTLE : S_EXEC;
            end
            S_EXEC: begin
                if (tmr_zero) begin
                    nxt = (cmd == CMD_ROT && rot_cnt == RC_W'(MAX_ROT)) ? S_HALT : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (tmr_zero) nxt = enable ? S_SAMPLE : S_IDLE;
            end
            S_HALT: begin
                nxt = S_HALT;
            end
            default: begin
                nxt = S_IDLE;
            end
        endcase
    end

    // Every state entry is a state change, so the timer reloads on any transition.
    always_comb begin
        tmr_load = (nxt != state);
        tmr_val  = '0;
        case (nxt)
            S_SAMPLE: tmr_val = TMR_W'(SENS_TIMEOUT - 1);
            S_EXEC:   tmr_val = (cmd_nxt == CMD_ROT) ? TMR_W'(ROT_CYCLES - 1)
                                                     : TMR_W'(MOVE_CYCLES - 1);
            S_SETTLE: tmr_val = TMR_W'(SETTLE_CYCLES - 1);
            default:  tmr_val = '0;
        endcase
    end

    robot_step_timer #(
        .TMR_W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (tmr_value),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cmd     <= CMD_NONE;
            head    <= 1'b0;
            left    <= 1'b0;
            rot_cnt <= '0;
            stuck   <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state <= nxt;
            cmd   <= cmd_nxt;
            if (state == S_SAMPLE && nxt == S_DECIDE) begin
                head <= sens_head;
                left <= sens_left;
            end
            // The rotate count is charged when the pulse is committed in DECIDE.
            if (state == S_DECIDE) begin
                if (cmd_nxt == CMD_ROT) begin
                    if (rot_cnt != RC_W'(MAX_ROT)) rot_cnt <= rot_cnt + RC_W'(1);
                end else if (cmd_nxt == CMD_FWD) begin
                    rot_cnt <= '0;
                end
            end
            if (state == S_EXEC && nxt == S_HALT)   stuck <= 1'b1;
            if (state == S_SAMPLE && nxt == S_HALT) fault <= 1'b1;
        end
    end

    assign sens_req  = (state == S_SAMPLE);
    assign nav_step  = (state == S_DECIDE) && !man_req;
    assign man_gnt   = (state == S_DECIDE) && man_req;
    assign motor_fwd = (state == S_EXEC) && (cmd == CMD_FWD);
    assign motor_rot = (state == S_EXEC) && (cmd == CMD_ROT);
    assign busy      = (state != S_IDLE) && (state != S_HALT);

    halt_timer_idle: assert property (@(posedge clk) disable iff (reset)
        (state == S_HALT) |-> (tmr_value == '0));

endmodule

// File: tb/tb_robot_move_scheduler.sv
// Bench for robot_move_scheduler: a phase/age model predicts every output each cycle,
// and directed steps pin pulse lengths, grants, timeouts and sticky flags.
module tb_robot_move_scheduler;

    localparam int MOVE_CYCLES   = 16;
    localparam int ROT_CYCLES    = 8;
    localparam int SETTLE_CYCLES = 4;
    localparam int SENS_TIMEOUT  = 32;
    localparam int MAX_ROT       = 4;

    localparam int P_IDLE = 0, P_SAMPLE = 1, P_DECIDE = 2, P_EXEC = 3, P_SETTLE = 4, P_HALT = 5;

    typedef struct packed {
        int phase;
        int age;
        int rots;
        bit fwd;
        bit rot;
        bit head;
        bit left;
        bit stuck;
        bit fault;
    } mdl_t;

    typedef struct {
        int req, nav, gnt, fwd, rot, gap;
        bit done, again, fault_seen;
        logic [9:0] after_rst;
    } step_res_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic sens_ack = 1'b0;
    logic sens_head = 1'b0, sens_left = 1'b0;
    logic nav_front = 1'b0, nav_rotate = 1'b0;
    logic man_req = 1'b0, man_front = 1'b0, man_rotate = 1'b0;
    logic sens_req, head, left, nav_step, man_gnt, motor_fwd, motor_rot, busy, stuck, fault;
    logic [9:0] dut_out;

    int n_checks = 0;
    int n_err = 0;
    int ack_delay = 2;
    int req_cnt = -1;
    mdl_t m;
    bit mdl_valid = 1'b0;

    robot_move_scheduler #(
        .MOVE_CYCLES   (MOVE_CYCLES),
        .ROT_CYCLES    (ROT_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .SENS_TIMEOUT  (SENS_TIMEOUT),
        .MAX_ROT       (MAX_ROT),
        .TMR_W         (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .sens_req   (sens_req),
        .sens_ack   (sens_ack),
        .sens_head  (sens_head),
        .sens_left  (sens_left),
        .head       (head),
        .left       (left),
        .nav_step   (nav_step),
        .nav_front  (nav_front),
        .nav_rotate (nav_rotate),
        .man_req    (man_req),
        .man_front  (man_front),
        .man_rotate (man_rotate),
        .man_gnt    (man_gnt),
        .motor_fwd  (motor_fwd),
        .motor_rot  (motor_rot),
        .busy       (busy),
        .stuck      (stuck),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    assign dut_out = {sens_req, head, left, nav_step, man_gnt, motor_fwd, motor_rot, busy, stuck, fault};

    function automatic mdl_t next_model(input mdl_t cur, input logic rst, en, ack, sh, sl,
                                        input logic nf, nr, mq, mf, mr);
        mdl_t n;
        logic f, r;
        n = cur;
        if (rst) begin
            n.phase = P_IDLE; n.age = 0; n.rots = 0; n.fwd = 0; n.rot = 0;
            n.head = 0; n.left = 0; n.stuck = 0; n.fault = 0;
            return n;
        end
        n.age = cur.age + 1;
        case (cur.phase)
            P_IDLE: if (en) begin n.phase = P_SAMPLE; n.age = 0; end
            P_SAMPLE: begin
                if (!en) begin
                    n.phase = P_IDLE; n.age = 0;
                end else if (ack) begin
                    n.head = sh; n.left = sl; n.phase = P_DECIDE; n.age = 0;
                end else if (n.age == SENS_TIMEOUT) begin
                    n.fault = 1; n.phase = P_HALT; n.age = 0;
                end
            end
            P_DECIDE: begin
                f = mq ? mf : nf;
                r = mq ? mr : nr;
                n.age = 0;
                n.rot = r;
                n.fwd = f & ~r;
                if (r) begin
                    n.rots = (cur.rots < MAX_ROT) ? cur.rots + 1 : MAX_ROT;
                    n.phase = P_EXEC;
                end else if (f) begin
                    n.rots = 0;
                    n.phase = P_EXEC;
                end else begin
                    n.phase = P_SETTLE;
                end
            end
            P_EXEC: begin
                if (n.age == (cur.rot ? ROT_CYCLES : MOVE_CYCLES)) begin
                    n.age = 0;
                    if (cur.rot && cur.rots == MAX_ROT) begin
                        n.stuck = 1; n.phase = P_HALT;
                    end else begin
                        n.phase = P_SETTLE;
                    end
                end
            end
            P_SETTLE: begin
                if (n.age == SETTLE_CYCLES) begin
                    n.age = 0;
                    n.phase = en ? P_SAMPLE : P_IDLE;
                end
            end
            default: n.age = 0;
        endcase
        return n;
    endfunction

    function automatic logic [9:0] expect_out(input mdl_t cur, input logic mq);
        return {cur.phase == P_SAMPLE, cur.head, cur.left,
                cur.phase == P_DECIDE && !mq, cur.phase == P_DECIDE && mq,
                cur.phase == P_EXEC && cur.fwd, cur.phase == P_EXEC && cur.rot,
                cur.phase inside {P_SAMPLE, P_DECIDE, P_EXEC, P_SETTLE},
                cur.stuck, cur.fault};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    initial begin : model_proc
        forever begin
            @(posedge clk);
            m = next_model(m, reset, enable, sens_ack, sens_head, sens_left,
                           nav_front, nav_rotate, man_req, man_front, man_rotate);
            if (reset) mdl_valid = 1'b1;
        end
    end

    initial begin : compare_proc
        logic [9:0] exp_v;
        forever begin
            @(negedge clk);
            #1;
            if (mdl_valid) begin
                exp_v = expect_out(m, man_req);
                n_checks++;
                if (dut_out !== exp_v) begin
                    n_err++;
                    $display("FAIL outputs t=%0t got=%b expected=%b (req,hd,lf,nav,gnt,fwd,rot,busy,stk,flt)",
                             $time, dut_out, exp_v);
                end
            end
        end
    end

    // Sensor model: acks ack_delay cycles after the request first appears; -1 never acks.
    initial begin : sensor_proc
        forever begin
            @(negedge clk);
            req_cnt = sens_req ? req_cnt + 1 : -1;
            sens_ack = (ack_delay >= 0) && sens_req && (req_cnt == ack_delay);
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; enable = 1'b0;
        nav_front = 1'b0; nav_rotate = 1'b0;
        man_req = 1'b0; man_front = 1'b0; man_rotate = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_step(input logic f, r, mq, mf, mr, input int drop_at, rst_at,
                           output step_res_t s);
        bit seen;
        int exec_idx;
        s.req = 0; s.nav = 0; s.gnt = 0; s.fwd = 0; s.rot = 0; s.gap = 0;
        s.done = 0; s.again = 0; s.fault_seen = 0; s.after_rst = '1;
        seen = 0;
        exec_idx = 0;
        @(negedge clk);
        nav_front = f; nav_rotate = r; man_req = mq; man_front = mf; man_rotate = mr;
        for (int t = 0; t < 200; t++) begin
            #2;
            s.req += int'(sens_req);
            s.nav += int'(nav_step);
            s.gnt += int'(man_gnt);
            s.fwd += int'(motor_fwd);
            s.rot += int'(motor_rot);
            if (fault) s.fault_seen = 1;
            if (nav_step || man_gnt) seen = 1;
            else if (seen && busy && !sens_req && !motor_fwd && !motor_rot) s.gap++;
            if (motor_fwd || motor_rot) begin
                exec_idx++;
                if (exec_idx == drop_at) enable = 1'b0;
                if (exec_idx == rst_at) reset = 1'b1;
            end
            if (reset) begin
                @(negedge clk);
                #2;
                s.after_rst = dut_out;
                reset = 1'b0;
                s.done = 1;
                break;
            end
            if (seen && (sens_req || !busy)) begin
                s.done = 1;
                s.again = sens_req;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin : stimulus
        step_res_t s;
        int req_n;
        int t;

        apply_reset();
        @(negedge clk); #2;
        chk("reset_outputs", 32'(dut_out), 0);

        // Forward step, ack two cycles after the request.
        sens_head = 1'b0; sens_left = 1'b1; ack_delay = 2;
        enable = 1'b1;
        do_step(1, 0, 0, 0, 0, 0, 0, s);
        chk("t1_done", 32'(s.done), 1);
        chk("t1_nav_step", s.nav, 1);
        chk("t1_gnt", s.gnt, 0);
        chk("t1_fwd_cycles", s.fwd, 16);
        chk("t1_rot_cycles", s.rot, 0);
        chk("t1_settle", s.gap, 4);
        chk("t1_req_again", 32'(s.again), 1);
        chk("t1_head", 32'(head), 0);
        chk("t1_left", 32'(left), 1);

        // Manual rotate wins the slot; the nav FSM is not stepped.
        sens_head = 1'b1; sens_left = 1'b0;
        do_step(0, 0, 1, 0, 1, 0, 0, s);
        chk("t2_done", 32'(s.done), 1);
        chk("t2_gnt", s.gnt, 1);
        chk("t2_nav_step", s.nav, 0);
        chk("t2_rot_cycles", s.rot, 8);
        chk("t2_fwd_cycles", s.fwd, 0);
        chk("t2_settle", s.gap, 4);
        chk("t2_head", 32'(head), 1);
        chk("t2_left", 32'(left), 0);

        // Four consecutive rotates trip the stuck halt after the fourth pulse.
        apply_reset();
        ack_delay = 0;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_step(0, 1, 0, 0, 0, 0, 0, s);
            chk($sformatf("t4a_rot%0d_cycles", i), s.rot, 8);
            chk($sformatf("t4a_rot%0d_settle", i), s.gap, (i == 3) ? 0 : 4);
            chk($sformatf("t4a_rot%0d_again", i), 32'(s.again), (i == 3) ? 0 : 1);
        end
        chk("t4a_stuck", 32'(stuck), 1);
        chk("t4a_busy", 32'(busy), 0);
        repeat (5) @(negedge clk);
        #2;
        chk("t4a_stuck_hold", 32'(stuck), 1);
        chk("t4a_req_hold", 32'(sens_req), 0);

        // A forward between rotates two and three restarts the count.
        apply_reset();
        enable = 1'b1;
        do_step(0, 1, 0, 0, 0, 0, 0, s);
        do_step(0, 1, 0, 0, 0, 0, 0, s);
        do_step(1, 0, 0, 0, 0, 0, 0, s);
        chk("t4b_fwd_cycles", s.fwd, 16);
        do_step(0, 1, 0, 0, 0, 0, 0, s);
        do_step(0, 1, 0, 0, 0, 0, 0, s);
        chk("t4b_rot_cycles", s.rot, 8);
        chk("t4b_stuck", 32'(stuck), 0);
        chk("t4b_busy", 32'(busy), 1);

        // Dropping enable mid-pulse finishes the step and parks in IDLE.
        do_step(1, 0, 0, 0, 0, 5, 0, s);
        chk("t5_fwd_cycles", s.fwd, 16);
        chk("t5_settle", s.gap, 4);
        chk("t5_again", 32'(s.again), 0);
        repeat (5) @(negedge clk);
        #2;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_req", 32'(sens_req), 0);

        // No ack ever: request held for the full timeout, then a latched fault.
        apply_reset();
        ack_delay = -1;
        enable = 1'b1;
        req_n = 0;
        for (t = 0; t < 100; t++) begin
            @(negedge clk);
            #2;
            req_n += int'(sens_req);
            if (!busy && req_n > 0) break;
        end
        chk("t3_in_budget", 32'(t < 100), 1);
        chk("t3_req_cycles", req_n, 32);
        chk("t3_fault", 32'(fault), 1);
        chk("t3_busy", 32'(busy), 0);
        repeat (10) @(negedge clk);
        #2;
        chk("t3_fault_hold", 32'(fault), 1);
        chk("t3_req_hold", 32'(sens_req), 0);

        // Ack in the expiry cycle proceeds; reset mid-pulse clears every output.
        apply_reset();
        ack_delay = 31;
        enable = 1'b1;
        do_step(1, 0, 0, 0, 0, 0, 3, s);
        chk("t6_done", 32'(s.done), 1);
        chk("t6_req_cycles", s.req, 32);
        chk("t6_nav_step", s.nav, 1);
        chk("t6_fault", 32'(s.fault_seen), 0);
        chk("t6_fwd_before_rst", s.fwd, 3);
        chk("t6_after_rst", 32'(s.after_rst), 0);
        enable = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
